// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared constants, state encoding and butterfly address helper for the 32-point FFT sequencer
package fft_ctrl_pkg;

    localparam int NFFT  = 32;
    localparam int LOG2N = 5;
    localparam int NBFLY = 16;

    // sample address / twiddle index width, butterfly index width, stage width, drain counter width
    localparam int AW = $clog2(NFFT);
    localparam int JW = $clog2(NBFLY);
    localparam int SW = 3;
    localparam int DW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] k;
    } bfly_addr_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
    } wb_slot_t;

    // Leg addresses and twiddle index of butterfly j in stage s (span half = 2^s).
    // grp << (s+1) leaves the low s+1 bits clear and pos < half, so OR equals add.
    function automatic bfly_addr_t bfly_addr(input logic [SW-1:0] s, input logic [JW-1:0] j);
        logic [AW-1:0] half;
        logic [AW-1:0] jx;
        logic [AW-1:0] grp;
        logic [AW-1:0] pos;
        bfly_addr_t    r;
        half = AW'(1) << s;
        jx   = {1'b0, j};
        grp  = jx >> s;
        pos  = jx & (half - AW'(1));
        r.a  = (grp << (s + SW'(1))) | pos;
        r.b  = r.a + half;
        r.k  = pos << (SW'(LOG2N - 1) - s);
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// rtl/fft_addr_delay.sv - BF_LAT-deep shift register turning read issues into write-backs
module fft_addr_delay
    import fft_ctrl_pkg::*;
#(
    parameter int BF_LAT = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr_a,
    input  logic [AW-1:0] i_addr_b,
    output logic          o_en,
    output logic [AW-1:0] o_addr_a,
    output logic [AW-1:0] o_addr_b
);

    wb_slot_t pipe [BF_LAT];

    // Shift one slot per cycle; reset empties every slot so in-flight writes are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{en: i_en, addr_a: i_addr_a, addr_b: i_addr_b};
            for (int i = 1; i < BF_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign o_en     = pipe[BF_LAT-1].en;
    assign o_addr_a = pipe[BF_LAT-1].addr_a;
    assign o_addr_b = pipe[BF_LAT-1].addr_b;

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - stage/butterfly sequencer for the in-place 32-point radix-2 DIT FFT
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int BF_LAT = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr_a,
    output logic [AW-1:0] o_rd_addr_b,
    output logic [AW-1:0] o_tw_k,
    output logic [SW-1:0] o_stage,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr_a,
    output logic [AW-1:0] o_wr_addr_b
);

    state_t        state;
    logic [JW-1:0] j;
    logic [SW-1:0] s;
    logic [DW-1:0] dcnt;

    bfly_addr_t first_bf;
    bfly_addr_t next_bf;
    bfly_addr_t next_stage_bf;

    // Candidate issues for the next cycle: very first butterfly, next in stage, first of next stage.
    assign first_bf      = bfly_addr('0, '0);
    assign next_bf       = bfly_addr(s, j + JW'(1));
    assign next_stage_bf = bfly_addr(s + SW'(1), '0);

    // Control FSM; all issue outputs are registered and default to 0 whenever no butterfly issues.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            j           <= '0;
            s           <= '0;
            dcnt        <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_k      <= '0;
            o_stage     <= '0;
        end else begin
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_k      <= '0;
            o_stage     <= '0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state       <= ST_RUN;
                        j           <= '0;
                        s           <= '0;
                        o_busy      <= 1'b1;
                        o_rd_en     <= 1'b1;
                        o_rd_addr_a <= first_bf.a;
                        o_rd_addr_b <= first_bf.b;
                        o_tw_k      <= first_bf.k;
                    end
                end
                ST_RUN: begin
                    if (j == JW'(NBFLY - 1)) begin
                        state <= ST_DRAIN;
                        dcnt  <= '0;
                    end else begin
                        j           <= j + JW'(1);
                        o_rd_en     <= 1'b1;
                        o_rd_addr_a <= next_bf.a;
                        o_rd_addr_b <= next_bf.b;
                        o_tw_k      <= next_bf.k;
                        o_stage     <= s;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DW'(BF_LAT - 1)) begin
                        if (s == SW'(LOG2N - 1)) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state       <= ST_RUN;
                            s           <= s + SW'(1);
                            j           <= '0;
                            o_rd_en     <= 1'b1;
                            o_rd_addr_a <= next_stage_bf.a;
                            o_rd_addr_b <= next_stage_bf.b;
                            o_tw_k      <= next_stage_bf.k;
                            o_stage     <= s + SW'(1);
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    s      <= '0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fft_addr_delay #(
        .BF_LAT(BF_LAT)
    ) u_delay (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (o_rd_en),
        .i_addr_a (o_rd_addr_a),
        .i_addr_b (o_rd_addr_b),
        .o_en     (o_wr_en),
        .o_addr_a (o_wr_addr_a),
        .o_addr_b (o_wr_addr_b)
    );

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - self-checking bench for fft_stage_sequencer at BF_LAT 1, 3 and 15
module tb_fft_stage_sequencer;

    localparam int NI = 3;
    localparam int L0 = 1;
    localparam int L1 = 3;
    localparam int L2 = 15;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;

    logic [NI-1:0]      busy, done, rd, wr;
    logic [NI-1:0][4:0] ra, rb, tk, wa, wb;
    logic [NI-1:0][2:0] st;

    always #5 clk = ~clk;

    fft_stage_sequencer #(.BF_LAT(L0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy[0]), .o_done(done[0]),
        .o_rd_en(rd[0]), .o_rd_addr_a(ra[0]), .o_rd_addr_b(rb[0]), .o_tw_k(tk[0]), .o_stage(st[0]),
        .o_wr_en(wr[0]), .o_wr_addr_a(wa[0]), .o_wr_addr_b(wb[0]));
    fft_stage_sequencer #(.BF_LAT(L1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy[1]), .o_done(done[1]),
        .o_rd_en(rd[1]), .o_rd_addr_a(ra[1]), .o_rd_addr_b(rb[1]), .o_tw_k(tk[1]), .o_stage(st[1]),
        .o_wr_en(wr[1]), .o_wr_addr_a(wa[1]), .o_wr_addr_b(wb[1]));
    fft_stage_sequencer #(.BF_LAT(L2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy[2]), .o_done(done[2]),
        .o_rd_en(rd[2]), .o_rd_addr_a(ra[2]), .o_rd_addr_b(rb[2]), .o_tw_k(tk[2]), .o_stage(st[2]),
        .o_wr_en(wr[2]), .o_wr_addr_a(wa[2]), .o_wr_addr_b(wb[2]));

    int errors = 0;
    int checks = 0;

    // butterfly tables built by enumerating groups and positions directly
    int ta [5][16];
    int tb2[5][16];
    int tkk[5][16];

    initial begin
        for (int s = 0; s < 5; s++) begin
            for (int g = 0; g < 16 / (1 << s); g++) begin
                for (int p = 0; p < (1 << s); p++) begin
                    ta [s][g * (1 << s) + p] = g * 2 * (1 << s) + p;
                    tb2[s][g * (1 << s) + p] = g * 2 * (1 << s) + p + (1 << s);
                    tkk[s][g * (1 << s) + p] = p * (16 / (1 << s));
                end
            end
        end
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? L0 : (i == 1) ? L1 : L2;
    endfunction

    // expected outputs t cycles after the start was sampled, from the timing rules
    function automatic logic [31:0] model_vec(input int L, input bit act, input int t);
        logic [31:0] v;
        int u, s, j;
        v = '0;
        if (act) begin
            v[31] = 1'b1;
            v[30] = (t == 81 + 5 * L);
            if (t >= 1 && t <= 80 + 4 * L) begin
                u = t - 1; s = u / (16 + L); j = u % (16 + L);
                if (j < 16) begin
                    v[29]    = 1'b1;
                    v[28:24] = 5'(ta[s][j]);
                    v[23:19] = 5'(tb2[s][j]);
                    v[18:14] = 5'(tkk[s][j]);
                    v[13:11] = 3'(s);
                end
            end
            if (t - L >= 1 && t - L <= 80 + 4 * L) begin
                u = t - L - 1; s = u / (16 + L); j = u % (16 + L);
                if (j < 16) begin
                    v[10]  = 1'b1;
                    v[9:5] = 5'(ta[s][j]);
                    v[4:0] = 5'(tb2[s][j]);
                end
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] dut_vec(input int i);
        return {busy[i], done[i], rd[i], ra[i], rb[i], tk[i], st[i], wr[i], wa[i], wb[i]};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // model phase per instance
    bit act[NI];
    int tm [NI];
    int cyc = 0;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (rst) act[i] = 1'b0;
            else if (act[i]) begin
                if (tm[i] == 81 + 5 * lat_of(i)) act[i] = 1'b0;
                else tm[i]++;
            end else if (start) begin
                act[i] = 1'b1;
                tm[i]  = 1;
            end
        end
    end

    // statistics and read->write scoreboard
    bit cmp_en = 1'b0;
    int t_ref  = 0;
    int rd_cnt[NI], wr_cnt[NI], wr_base[NI], nrs[NI], done_cnt[NI], done_cyc[NI];
    int runstart[NI][4];
    bit rd_prev[NI];
    logic [31:0] hist1 [512];
    logic [9:0] q0[$], q1[$], q2[$];

    task automatic sb_push(input int i, input logic [9:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int i, input logic [9:0] w);
        logic [9:0] r;
        bit ok;
        ok = 1'b1;
        r  = '0;
        case (i)
            0: if (q0.size() == 0) ok = 1'b0; else r = q0.pop_front();
            1: if (q1.size() == 0) ok = 1'b0; else r = q1.pop_front();
            default: if (q2.size() == 0) ok = 1'b0; else r = q2.pop_front();
        endcase
        if (!ok) chk($sformatf("wr_without_rd_inst%0d", i), 1, 0);
        else     chk($sformatf("wr_pair_inst%0d", i), int'(w), int'(r));
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NI; i++) begin
            rd_cnt[i] = 0; wr_cnt[i] = 0; wr_base[i] = 0; nrs[i] = 0;
            done_cnt[i] = 0; done_cyc[i] = -1;
            for (int n = 0; n < 4; n++) runstart[i][n] = -1;
        end
    endtask

    // per-cycle comparison against the model plus hazard and pairing bookkeeping
    always @(negedge clk) begin : cmp
        logic [31:0] got, expv;
        int rel;
        if (cmp_en) begin
            rel = cyc - t_ref;
            for (int i = 0; i < NI; i++) begin
                got  = dut_vec(i);
                expv = model_vec(lat_of(i), act[i], tm[i]);
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL outputs inst%0d rel=%0d got=%h expected=%h", i, rel, got, expv);
                end
                if (i == 1 && rel >= 0 && rel < 512) hist1[rel] = got;
                if (rd[i] === 1'b1) begin
                    if (!rd_prev[i]) begin
                        if (st[i] == 3'd0) begin
                            wr_base[i] = wr_cnt[i];
                            if (nrs[i] < 4) runstart[i][nrs[i]] = rel;
                            nrs[i]++;
                        end else begin
                            chk($sformatf("hazard_inst%0d_stage%0d", i, st[i]),
                                wr_cnt[i] - wr_base[i], 16 * int'(st[i]));
                        end
                    end
                    rd_cnt[i]++;
                    sb_push(i, {ra[i], rb[i]});
                end
                if (wr[i] === 1'b1) begin
                    sb_pop(i, {wa[i], wb[i]});
                    wr_cnt[i]++;
                end
                if (done[i] === 1'b1) begin
                    if (done_cnt[i] == 0) done_cyc[i] = rel;
                    done_cnt[i]++;
                end
                rd_prev[i] = rd[i];
            end
            if (rst) begin
                q0.delete(); q1.delete(); q2.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spot(input string name, input int rel, input int a, input int b, input int k, input int s);
        chk({name, "_rd"}, int'(hist1[rel][29]), 1);
        chk({name, "_a"},  int'(hist1[rel][28:24]), a);
        chk({name, "_b"},  int'(hist1[rel][23:19]), b);
        chk({name, "_k"},  int'(hist1[rel][18:14]), k);
        chk({name, "_s"},  int'(hist1[rel][13:11]), s);
    endtask

    int done_exp[NI] = '{86, 96, 156};
    int w41[NI];

    initial begin
        clear_stats();
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) chk($sformatf("reset_state_inst%0d", i), int'(dut_vec(i)), 0);
        chk("model_s1j3_a", ta[1][3], 5);
        chk("model_s2j5_b", tb2[2][5], 13);
        chk("model_s4j15_k", tkk[4][15], 15);
        rst = 1'b0;
        tick();

        // single start pulse
        start = 1'b1; t_ref = cyc; clear_stats();
        tick();
        start = 1'b0;
        repeat (170) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("first_rd_inst%0d", i), runstart[i][0], 1);
            chk($sformatf("rd_count_inst%0d", i), rd_cnt[i], 80);
            chk($sformatf("wr_count_inst%0d", i), wr_cnt[i], 80);
            chk($sformatf("done_cycle_inst%0d", i), done_cyc[i], done_exp[i]);
            chk($sformatf("done_count_inst%0d", i), done_cnt[i], 1);
        end
        spot("first_bf", 1, 0, 1, 0, 0);
        spot("s0j7", 8, 14, 15, 0, 0);
        spot("s1j3", 23, 5, 7, 8, 1);
        spot("s2j5", 44, 9, 13, 4, 2);
        spot("s4j15", 92, 15, 31, 15, 4);
        chk("done_at_96", int'(hist1[96][30]), 1);
        chk("busy_after_done", int'(hist1[97][31]), 0);

        // start held high for 200 cycles
        tick();
        start = 1'b1; t_ref = cyc; clear_stats();
        repeat (200) tick();
        start = 1'b0;
        repeat (200) tick();
        chk("held_second_start", runstart[1][1], 98);
        chk("held_runs_inst0", nrs[0], 3);
        chk("held_runs_inst1", nrs[1], 3);
        chk("held_runs_inst2", nrs[2], 2);
        chk("held_done_inst0", done_cnt[0], 3);
        chk("held_done_inst1", done_cnt[1], 3);
        chk("held_done_inst2", done_cnt[2], 2);

        // reset at cycle 40 mid-transform
        tick();
        start = 1'b1; t_ref = cyc; clear_stats();
        tick();
        start = 1'b0;
        repeat (39) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_outputs_zero_inst%0d", i), int'(dut_vec(i)), 0);
            w41[i] = wr_cnt[i];
        end
        repeat (20) tick();
        for (int i = 0; i < NI; i++) chk($sformatf("no_wr_after_rst_inst%0d", i), wr_cnt[i] - w41[i], 0);
        start = 1'b1; t_ref = cyc; clear_stats();
        tick();
        start = 1'b0;
        repeat (170) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("restart_rd_count_inst%0d", i), rd_cnt[i], 80);
            chk($sformatf("restart_wr_count_inst%0d", i), wr_cnt[i], 80);
            chk($sformatf("restart_done_inst%0d", i), done_cyc[i], done_exp[i]);
        end
        spot("restart_first", 1, 0, 1, 0, 0);
        spot("restart_s0j7", 8, 14, 15, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
